// File: rtl/ecap5_dproc_pkg.sv
// ecap5_dproc_pkg: arbiter state encoding and master index constants
package ecap5_dproc_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_M0, GRANT_M1} arb_state_t;
  localparam int ARB_M0 = 0;
  localparam int ARB_M1 = 1;
endpackage

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-master pipelined Wishbone arbiter (m0 = instruction fetch, m1 = load-store)
// Ports: clk_i, rst_i (async, active-low); m0_*/m1_* master-facing request/response;
//        wb_* shared-bus master port; grant_o one-hot owner (bit0 = m0, bit1 = m1).
// Build option: WB_ARBITER_RR_EN selects round-robin tie-break; undefined, m1 wins ties.
module wb_arbiter
  import ecap5_dproc_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_stall_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_stall_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i,
  output logic [1:0]  grant_o
);
  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTST);
  arb_state_t state;
  logic [1:0] grant;
  logic [CW-1:0] cnt, cnt_nxt;
  logic g0, g1, busy, full, inc, dec, pick_m1;
  logic s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat;
  logic [3:0] s_sel;
  assign g0 = grant[ARB_M0];
  assign g1 = grant[ARB_M1];
  assign busy = g0 | g1;
  assign grant_o = grant;
  // Selected master's request; all zero when idle so the bus idles at 0.
  always_comb begin
    s_cyc = g1 ? m1_cyc_i : g0 & m0_cyc_i;
    s_stb = g1 ? m1_stb_i : g0 & m0_stb_i;
    s_we  = g1 ? m1_we_i  : g0 & m0_we_i;
    s_adr = g1 ? m1_adr_i : g0 ? m0_adr_i : '0;
    s_dat = g1 ? m1_dat_i : g0 ? m0_dat_i : '0;
    s_sel = g1 ? m1_sel_i : g0 ? m0_sel_i : '0;
  end
  assign full = cnt == CMAX;
  // cyc stays up after the master drops it until every accepted request is acked.
  assign wb_cyc_o = busy & (s_cyc | (cnt != '0));
  assign wb_stb_o = s_cyc & s_stb & !full;
  assign wb_we_o  = s_we;
  assign wb_adr_o = s_adr;
  assign wb_dat_o = s_dat;
  assign wb_sel_o = s_sel;
  assign inc = wb_stb_o & !wb_stall_i;
  assign dec = busy & wb_ack_i & (cnt != '0);
  assign cnt_nxt = cnt + CW'(inc) - CW'(dec);
  assign m0_stall_o = g0 ? wb_stall_i | full : 1'b1;
  assign m1_stall_o = g1 ? wb_stall_i | full : 1'b1;
  assign m0_ack_o = g0 & wb_ack_i;
  assign m1_ack_o = g1 & wb_ack_i;
  assign m0_dat_o = g0 ? wb_dat_i : '0;
  assign m1_dat_o = g1 ? wb_dat_i : '0;
`ifdef WB_ARBITER_RR_EN
  logic last_m1;
  // On a tie, the master that did not own the bus last wins.
  assign pick_m1 = m1_cyc_i & (!m0_cyc_i | !last_m1);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) last_m1 <= 1'b0;
    else if (state == IDLE && (m0_cyc_i | m1_cyc_i)) last_m1 <= pick_m1;
  end
`else
  assign pick_m1 = m1_cyc_i;
`endif
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      grant <= 2'b00;
      cnt   <= '0;
    end else begin
      cnt <= cnt_nxt;
      case (state)
        IDLE:
          if (m0_cyc_i | m1_cyc_i) begin
            state <= pick_m1 ? GRANT_M1 : GRANT_M0;
            grant <= pick_m1 ? 2'b10 : 2'b01;
          end
        GRANT_M0, GRANT_M1:
          if (!s_cyc && cnt_nxt == '0) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter with a pipelined slave model
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst_i;
  logic m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0] m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic m0_ack_o, m0_stall_o, m1_ack_o, m1_stall_o;
  logic wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0] wb_sel_o;
  logic wb_ack_i, wb_stall_i;
  logic [1:0] grant_o;
  typedef struct { bit m; logic [31:0] d; } exp_t;
  typedef struct { logic [31:0] a; int due; } pend_t;
  exp_t exp_q[$];
  pend_t pend[$];
  exp_t e;
  pend_t p;
  int vectors = 0, miscompares = 0, m1_acks = 0, lat = 1, cyc_n = 0, base;
  bit no_ack = 1'b0, acc;
  logic [31:0] acc_a;
  logic [1:0] tie2_exp;

  wb_arbiter #(.MAX_OUTST(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_stall_o(m0_stall_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_stall_o(m1_stall_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_stall_i(wb_stall_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic drv(input bit m, input bit cyc, input bit stb, input logic [31:0] adr,
                     input bit we = 1'b0, input logic [31:0] dat = 32'h0, input logic [3:0] sel = 4'hF);
    if (m) begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_we_i = we; m1_dat_i = dat; m1_sel_i = sel;
    end else begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_we_i = we; m0_dat_i = dat; m0_sel_i = sel;
    end
  endtask

  task automatic push(input bit m, input logic [31:0] adr);
    exp_q.push_back('{m, rdat(adr)});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) smp();
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle(input string tag);
    for (int i = 0; i < 20 && grant_o != 2'b00; i++) smp();
    chk(tag, grant_o, 0);
  endtask

  // Slave: accepts on stb & !stall, acks in order after lat cycles, noisy while in reset.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      acc = wb_stb_o && !wb_stall_i;
      acc_a = wb_adr_o;
      @(posedge clk);
      #1;
      cyc_n++;
      if (!rst_i) begin
        pend.delete();
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEADBEEF;
      end else begin
        if (acc) pend.push_back('{acc_a, cyc_n + lat - 1});
        if (!no_ack && pend.size() != 0 && pend[0].due <= cyc_n) begin
          p = pend.pop_front();
          wb_ack_i = 1'b1;
          wb_dat_i = rdat(p.a);
        end else begin
          wb_ack_i = 1'b0;
          wb_dat_i = 32'hDEADBEEF;
        end
      end
    end
  end

  // Response monitor: every forwarded ack must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (m0_ack_o || m1_ack_o) begin
      if (exp_q.size() == 0) chk("spurious_ack", {m1_ack_o, m0_ack_o}, 0);
      else begin
        e = exp_q.pop_front();
        chk("ack_src", m1_ack_o, e.m);
        chk("rdata", m1_ack_o ? m1_dat_o : m0_dat_o, e.d);
      end
      if (m1_ack_o) m1_acks++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b0;
    wb_stall_i = 1'b0;
    drv(0, 0, 0, 0);
    drv(1, 0, 0, 0);
    repeat (2) smp();
    chk("rst_grant", grant_o, 0);
    chk("rst_wb_cyc", wb_cyc_o, 0);
    chk("rst_wb_adr", wb_adr_o, 0);
    chk("rst_stall", {m1_stall_o, m0_stall_o}, 2'b11);
    chk("rst_ack", {m1_ack_o, m0_ack_o}, 0);
    chk("rst_dat", m0_dat_o | m1_dat_o, 0);
    rst_i = 1'b1;
    // single m0 read, with one forwarded slave stall
    tick(); drv(0, 1, 1, 32'h100);
    smp(); chk("t1_wait", grant_o, 0); chk("t1_idle_stb", wb_stb_o, 0);
    tick(); wb_stall_i = 1'b1;
    smp(); chk("t1_grant", grant_o, 2'b01); chk("t1_adr", wb_adr_o, 32'h100);
    chk("t1_m1_stall", m1_stall_o, 1); chk("t1_fwd_stall", m0_stall_o, 1);
    tick(); wb_stall_i = 1'b0;
    smp(); chk("t1_go", m0_stall_o, 0); push(0, 32'h100);
    tick(); drv(0, 1, 0, 32'h100);
    drain("t1_drain");
    drv(0, 0, 0, 0);
    idle("t1_idle");
    // tie in idle, then a second tie after m1 releases
    tick(); drv(0, 1, 0, 0); drv(1, 1, 0, 0);
    smp(); chk("t2_wait", grant_o, 0);
    tick();
    smp(); chk("t2_tie", grant_o, 2'b10); chk("t2_m0_stall", m0_stall_o, 1);
    chk("t2_cyc", wb_cyc_o, 1); chk("t2_stb", wb_stb_o, 0);
    tick(); drv(1, 0, 0, 0);
    tick(); drv(1, 1, 0, 0);
    smp(); chk("t2_gap", grant_o, 0);
    tick();
`ifdef WB_ARBITER_RR_EN
    tie2_exp = 2'b01;
`else
    tie2_exp = 2'b10;
`endif
    smp(); chk("t2_tie2", grant_o, tie2_exp);
    tick(); drv(0, 0, 0, 0); drv(1, 0, 0, 0);
    idle("t2_idle");
    // m1 three pipelined stores, latency 2, cyc dropped after the third accept
    lat = 2;
    base = m1_acks;
    tick(); drv(1, 1, 1, 32'h1000, 1, 32'hA0A0_0001, 4'h3);
    smp(); chk("t3_wait", grant_o, 0);
    tick(); drv(0, 1, 1, 32'h300);
    smp(); chk("t3_grant", grant_o, 2'b10); chk("t3_we", wb_we_o, 1);
    chk("t3_wdat", wb_dat_o, 32'hA0A0_0001); chk("t3_sel", wb_sel_o, 4'h3);
    chk("t3_m0_stall", m0_stall_o, 1); push(1, 32'h1000);
    tick(); drv(1, 1, 1, 32'h1004, 1, 32'hA0A0_0002, 4'hC);
    smp(); chk("t3_adr1", wb_adr_o, 32'h1004); push(1, 32'h1004);
    tick(); drv(1, 1, 1, 32'h1008, 1, 32'hA0A0_0003, 4'hF);
    smp(); push(1, 32'h1008);
    tick(); drv(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      smp();
      if (m1_acks - base >= 3) break;
      chk("t3_hold", grant_o, 2'b10);
    end
    chk("t3_acks", m1_acks - base, 3);
    lat = 1;
    smp(); chk("t3_handover_idle", grant_o, 0);
    smp(); chk("t3_m0_grant", grant_o, 2'b01); push(0, 32'h300);
    tick(); drv(0, 1, 0, 32'h300);
    drain("t3_drain");
    drv(0, 0, 0, 0);
    idle("t3_idle");
    // slave never acks: counter saturates at 4, strobes 5 and 6 stalled
    no_ack = 1'b1;
    tick(); drv(0, 1, 1, 32'h400);
    smp();
    tick();
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("t4_stall", m0_stall_o, i >= 4);
      chk("t4_stb", wb_stb_o, i < 4);
      if (i < 4) push(0, 32'h400 + 32'(4 * i));
      tick(); drv(0, 1, 1, 32'h400 + 32'(4 * (i + 1)));
    end
    drv(0, 1, 0, 0);
    smp(); chk("t4_cyc_held", wb_cyc_o, 1);
    no_ack = 1'b0;
    drain("t4_drain");
    drv(0, 0, 0, 0);
    idle("t4_idle");
    // reset during a pending read
    no_ack = 1'b1;
    tick(); drv(0, 1, 1, 32'h500);
    smp();
    tick();
    smp(); chk("t5_grant", grant_o, 2'b01); chk("t5_dat_pass", m0_dat_o, 32'hDEADBEEF);
    tick(); drv(0, 1, 0, 32'h500);
    smp();
    rst_i = 1'b0;
    #1;
    chk("t5_rst_cyc", wb_cyc_o, 0); chk("t5_rst_stb", wb_stb_o, 0);
    chk("t5_rst_adr", wb_adr_o, 0); chk("t5_rst_grant", grant_o, 0);
    chk("t5_rst_ack", m0_ack_o, 0); chk("t5_rst_stall", m0_stall_o, 1);
    chk("t5_rst_dat", m0_dat_o, 0);
    exp_q.delete();
    smp(); chk("t5_rst_noack", {m1_ack_o, m0_ack_o}, 0); chk("t5_rst_dat2", m0_dat_o, 0);
    no_ack = 1'b0;
    rst_i = 1'b1;
    drv(0, 1, 1, 32'h600);
    smp(); chk("t5_regrant", grant_o, 2'b01); push(0, 32'h600);
    tick(); drv(0, 1, 0, 32'h600);
    drain("t5_drain");
    drv(0, 0, 0, 0);
    idle("t5_idle");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
